rice_optimizer: RTL and testbench
=================================

Name: rice_optimizer

Overview:
- Streams one block of signed 16-bit LPC residuals and accumulates, for every Rice parameter k in 0..NUM_K-1, the exact Rice-coded bit count of the block.
- At end of block, selects the k with the minimum total and reports it on oBest with a one-cycle oDone pulse.
- Sits after the residual encoder stage. Feeds the Rice encoder/writer its partition parameter.

Parameters:
- BLOCK_SIZE, 4096: residuals per block.
- NUM_K, 15: number of candidate Rice parameters (k = 0..14).
- ACC_W, 32: accumulator width. Worst case is (65535+1)*4096 = 2^28, so 32 bits never overflows.

Ports:
- iClock  in  1  rising-edge clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  global enable. Low freezes all state and outputs.
- iValid  in  1  iResidual is valid this cycle.
- iResidual  in  16  signed two's-complement residual.
- oDone  out  1  one-cycle pulse: oBest is valid for the block just finished.
- oBest  out  4  optimal Rice parameter, 0..NUM_K-1.

Behaviour:
- Clock and reset: one clock, iClock. Reset is synchronous and active-high on iReset. Reset has priority over iEnable.
- Reset state: all accumulators 0, sample count 0, state ACCUM, zigzag pipe register invalid, oDone 0, oBest 0.
- Zigzag mapping: u = (r >= 0) ? 2r : -2r-1, giving a 16-bit unsigned value. For example, -32768 maps to 65535 and 32767 maps to 65534.
- Per-sample cost for parameter k: 1 + k + (u >> k).
- States: ACCUM, FLUSH, COMPARE, DONE.
- ACCUM:
  - Each edge with iEnable & iValid: register u (pipe stage 1) and increment the sample count.
  - On the next edge, add cost(k) to acc[k] for all k in parallel (stage 2).
  - When the BLOCK_SIZE-th sample is accepted, go to FLUSH.
- FLUSH: one cycle, so the last sample's accumulate completes.
- COMPARE:
  - Scan k = 0..NUM_K-1, one k per cycle (NUM_K cycles).
  - Track min and argmin. Replace only on strictly-less, so ties resolve to the smallest k.
- DONE:
  - oDone = 1 for exactly one cycle; oBest = argmin, registered.
  - Clear accumulators and count, return to ACCUM.
- oBest holds its value until the next DONE or reset.
- Latency: the last sample is accepted at edge t. oDone is high in the cycle after edge t+NUM_K+2, i.e. 17 cycles after the last sample with the defaults.
- iValid during FLUSH, COMPARE or DONE is ignored; those samples are dropped. Upstream must gap NUM_K+2 cycles between blocks, or reset.
- iValid with iEnable low is ignored. iEnable low mid-COMPARE pauses the scan.
- Reset mid-block: discards partial sums. The next accepted sample is sample 0 of a new block, and no oDone is produced for the aborted block.
- Reset in the same cycle as DONE: reset wins, so oDone is 0 on the following cycle.
- Accumulation is unsigned. Overflow is impossible by width choice.

Decomposition:
- Shared package holds:
  - constants BLOCK_SIZE, NUM_K, ACC_W;
  - a zigzag function;
  - an enum for states ACCUM/FLUSH/COMPARE/DONE.
- One natural sub-module: rice_cost_accumulator, one instance per k with k as a parameter. It holds acc[k] and performs the add of 1+k+(u>>k), with clear and enable inputs.
- Comparison and the FSM stay in the top module.

Test Plan:
- All-zero block of 4096 residuals: acc[k] = 4096*(k+1), so oBest = 0. oDone pulses exactly once, 17 cycles after the last sample.
- Block of all +1 (u=2): k = 0, 1 and 2 all cost 3 per sample, a tie, so oBest = 0 (tie goes to the lowest k).
- Block of all +100 (u=200): costs per sample for k=0..8 are 201, 102, 53, 29, 17, 12, 10, 9, 9, so oBest = 7.
- Block of all -32768 (u=65535): k=13 costs 21 per sample, k=14 costs 18, so oBest = 14. Check acc[0] = 65536*4096 with no overflow.
- Four back-to-back blocks with iReset pulsed on each oDone (values 0, 100, 1, -32768 per block): oBest sequence is 0, 7, 0, 14.
- Reset asserted after 2000 samples, then a full block of +100: only one oDone, with oBest = 7. Also toggle iEnable low mid-block and confirm the result is unchanged.

Source files
------------

// File: rtl/rice_optimizer_pkg.sv
// rice_optimizer_pkg
//   Shared constants, FSM state encoding and the residual zigzag mapping
//   used by the Rice parameter optimizer and its per-k cost accumulators.
package rice_optimizer_pkg;

  localparam int BLOCK_SIZE = 4096;  // residuals per block
  localparam int NUM_K      = 15;    // candidate Rice parameters k = 0..NUM_K-1
  localparam int ACC_W      = 32;    // per-k bit-count accumulator width
  localparam int DATA_W     = 16;    // residual width
  localparam int K_W        = 4;     // width of a Rice parameter index
  localparam int CNT_W      = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    COMPARE,
    DONE
  } state_t;

  // Signed residual to unsigned Rice symbol: r >= 0 -> 2r, r < 0 -> -2r-1.
  // Shift-and-xor form never overflows, e.g. -32768 -> 65535.
  function automatic logic [DATA_W-1:0] zigzag(input logic signed [DATA_W-1:0] r);
    return {r[DATA_W-2:0], 1'b0} ^ {DATA_W{r[DATA_W-1]}};
  endfunction

endpackage

// File: rtl/rice_cost_accumulator.sv
// rice_cost_accumulator
//   Holds the running Rice-coded bit count of one block for a single
//   parameter K. Each add cycle accumulates 1 + K + (u >> K).
//   Ports:
//     clk   - rising-edge clock
//     rst   - synchronous active-high reset (clears the sum)
//     clear - end-of-block clear (synchronous)
//     add   - accumulate the cost of u this cycle
//     u     - zigzag-mapped residual
//     acc   - running bit count
module rice_cost_accumulator
  import rice_optimizer_pkg::*;
#(
  parameter int K = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] u,
  output logic [ACC_W-1:0]  acc
);

  // unary terminator bit plus K binary bits
  localparam logic [ACC_W-1:0] BASE = ACC_W'(1 + K);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + BASE + ACC_W'(u >> K);
    end
  end

endmodule

// File: rtl/rice_optimizer.sv
// rice_optimizer
//   Accumulates, for every Rice parameter k, the exact coded size of one
//   block of residuals, then scans the totals and reports the cheapest k.
//   Ports:
//     iClock    - rising-edge clock
//     iReset    - synchronous active-high reset (priority over iEnable)
//     iEnable   - global enable; low freezes all state and outputs
//     iValid    - iResidual valid this cycle
//     iResidual - signed 16-bit residual
//     oDone     - one-cycle pulse, oBest valid for the block just finished
//     oBest     - optimal Rice parameter, held until the next block result
module rice_optimizer
  import rice_optimizer_pkg::*;
(
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEnable,
  input  logic                     iValid,
  input  logic signed [DATA_W-1:0] iResidual,
  output logic                     oDone,
  output logic [K_W-1:0]           oBest
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(NUM_K - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [K_W-1:0]     scan_idx;
  logic [K_W-1:0]     argmin;
  logic [ACC_W-1:0]   min_val;
  logic [ACC_W-1:0]   acc [NUM_K];
  logic [ACC_W-1:0]   acc_sel;
  logic               vld_p1;
  logic [DATA_W-1:0]  u_p1;
  logic               accept;
  logic               last_sample;
  logic               last_k;

  assign accept      = iEnable & iValid & (state == ACCUM);
  assign last_sample = (count == LAST_CNT);
  assign last_k      = (scan_idx == LAST_K);
  assign acc_sel     = acc[scan_idx];

  // FSM state register
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last_sample) state_nxt = FLUSH;
      FLUSH:   if (iEnable) state_nxt = COMPARE;
      COMPARE: if (iEnable && last_k) state_nxt = DONE;
      DONE:    if (iEnable) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Stage p1: zigzag-mapped residual and its valid
  always_ff @(posedge iClock) begin
    if (accept) begin
      u_p1 <= zigzag(iResidual);
    end
  end

  // Control: sample count, pipe valid, scan index and result outputs
  always_ff @(posedge iClock) begin
    if (iReset) begin
      count    <= '0;
      vld_p1   <= 1'b0;
      scan_idx <= '0;
      oDone    <= 1'b0;
      oBest    <= '0;
    end else if (iEnable) begin
      vld_p1 <= accept;
      oDone  <= (state == DONE);
      if (accept) begin
        count <= last_sample ? '0 : count + 1'b1;
      end
      if (state == COMPARE) begin
        scan_idx <= last_k ? '0 : scan_idx + 1'b1;
      end
      if (state == DONE) begin
        count <= '0;
        oBest <= argmin;
      end
    end
  end

  // Compare scan: first k seeds the minimum, later ones replace only on
  // strictly-less so ties keep the smallest k.
  always_ff @(posedge iClock) begin
    if (iEnable && state == COMPARE) begin
      if (scan_idx == '0 || acc_sel < min_val) begin
        min_val <= acc_sel;
        argmin  <= scan_idx;
      end
    end
  end

  // Stage p2: every k accumulates the p1 sample's cost in parallel
  for (genvar k = 0; k < NUM_K; k++) begin : g_acc
    rice_cost_accumulator #(
      .K(k)
    ) u_acc (
      .clk   (iClock),
      .rst   (iReset),
      .clear (iEnable & (state == DONE)),
      .add   (iEnable & vld_p1),
      .u     (u_p1),
      .acc   (acc[k])
    );
  end

endmodule

// File: tb/tb_rice_optimizer.sv
// tb_rice_optimizer
//   Directed and randomized blocks against a per-k bit-count model.
module tb_rice_optimizer;
  import rice_optimizer_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               vld;
  logic signed [15:0] res;
  logic               done;
  logic [3:0]         best;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  longint unsigned mcost [NUM_K];

  always #5 clk = ~clk;

  rice_optimizer dut (
    .iClock    (clk),
    .iReset    (rst),
    .iEnable   (en),
    .iValid    (vld),
    .iResidual (res),
    .oDone     (done),
    .oBest     (best)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned zz(input int r);
    return (r >= 0) ? longint'(2 * r) : longint'(-2 * r - 1);
  endfunction

  function automatic int model_best();
    int b = 0;
    for (int k = 1; k < NUM_K; k++) if (mcost[k] < mcost[b]) b = k;
    return b;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_K; k++) mcost[k] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives nsamp back-to-back samples: constant val, or uniform in [-val, val].
  // With toggle set, enable drops for 3 cycles now and then while iValid stays high.
  task automatic send_block(input bit rnd, input int val, input bit toggle, input int nsamp);
    int r;
    for (int i = 0; i < nsamp; i++) begin
      if (toggle && (i % 1000) == 500) begin
        en  = 1'b0;
        vld = 1'b1;
        res = 16'sh7fff;
        repeat (3) step();
        en = 1'b1;
      end
      if (rnd) r = int'($urandom_range(2 * val)) - val;
      else     r = val;
      res = r[15:0];
      vld = 1'b1;
      for (int k = 0; k < NUM_K; k++) mcost[k] += longint'(1 + k) + (zz(r) >> k);
      step();
    end
    vld = 1'b0;
    res = '0;
  endtask

  task automatic finish_block(input string tag, input int exp_best, input bit rst_on_done);
    int n;
    int d0;
    bit seen;
    d0   = done_cnt;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (n == 2) begin
        check({tag, "_acc0"}, dut.acc[0], mcost[0]);
        check({tag, "_acc14"}, dut.acc[NUM_K-1], mcost[NUM_K-1]);
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, n, 17);
    check({tag, "_best"}, best, exp_best);
    if (rst_on_done) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      check({tag, "_rst_best"}, best, 0);
      check({tag, "_rst_done"}, done, 0);
    end else begin
      step();
      check({tag, "_pulse"}, done, 0);
      check({tag, "_hold"}, best, exp_best);
    end
    check({tag, "_ndone"}, done_cnt - d0, 1);
    model_clear();
  endtask

  initial begin
    int d0;
    int vals [4] = '{0, 100, 1, -32768};
    int exps [4] = '{0, 7, 0, 14};
    rst = 1'b1;
    en  = 1'b1;
    vld = 1'b0;
    res = '0;
    model_clear();
    repeat (3) step();
    check("reset_done", done, 0);
    check("reset_best", best, 0);
    check("reset_acc0", dut.acc[0], 0);
    rst = 1'b0;
    step();

    send_block(1'b0, 0, 1'b0, BLOCK_SIZE);
    check("zero_model", mcost[3], 4 * BLOCK_SIZE);
    finish_block("zero", 0, 1'b0);

    send_block(1'b0, 1, 1'b0, BLOCK_SIZE);
    finish_block("ones", 0, 1'b0);

    send_block(1'b0, 100, 1'b0, BLOCK_SIZE);
    finish_block("hundred", 7, 1'b0);

    send_block(1'b0, -32768, 1'b0, BLOCK_SIZE);
    check("min_model_acc0", mcost[0], 64'd65536 * BLOCK_SIZE);
    finish_block("min", 14, 1'b0);

    for (int b = 0; b < 4; b++) begin
      send_block(1'b0, vals[b], 1'b0, BLOCK_SIZE);
      finish_block($sformatf("b2b%0d", b), exps[b], 1'b1);
    end

    // aborted partial block followed by a full block with enable gaps
    d0 = done_cnt;
    send_block(1'b1, 3000, 1'b0, 2000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    send_block(1'b0, 100, 1'b1, BLOCK_SIZE);
    check("abort_nodone", done_cnt - d0, 0);
    finish_block("abort", 7, 1'b0);

    // reset landing on the DONE cycle suppresses the pulse
    d0 = done_cnt;
    send_block(1'b1, 50, 1'b0, BLOCK_SIZE);
    repeat (16) step();
    check("donerst_state", dut.state, DONE);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("donerst_done", done, 0);
    check("donerst_best", best, 0);
    repeat (3) step();
    check("donerst_ndone", done_cnt - d0, 0);
    model_clear();

    send_block(1'b1, 40, 1'b1, BLOCK_SIZE);
    finish_block("rand40", model_best(), 1'b0);

    send_block(1'b1, 5000, 1'b0, BLOCK_SIZE);
    finish_block("rand5000", model_best(), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
